// File: rtl/ws2812_pkg.sv
// ----------------------------------------------------------------------------
// ws2812_pkg
// Shared definitions for the WS2812 pixel pipeline: frame-sequencer state
// encoding, the system clock rate, pixel/colour field geometry and the
// wire-order reorder helper used by both the frame streamer and the
// serializer side.
// ----------------------------------------------------------------------------
package ws2812_pkg;

    // System clock rate; used to derive default frame/colour periods.
    localparam int CLK_HZ = 50_000_000;

    // Pixel geometry: {R[23:16], G[15:8], B[7:0]} as written by the host.
    localparam int PIX_W = 24;
    localparam int COL_W = 8;
    localparam int R_OFS = 16;
    localparam int G_OFS = 8;
    localparam int B_OFS = 0;

    typedef logic [PIX_W-1:0] pixel_t;

    // Frame sequencer states (plain 2-bit constants for legacy tooling).
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_LOAD   = 2'd1;
    localparam logic [1:0] ST_STREAM = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    // Convert host RGB order into the order the LEDs expect on the wire.
    // grb=1 yields {G,R,B}; grb=0 passes {R,G,B} through unchanged.
    function automatic pixel_t grb_reorder(input pixel_t rgb, input logic grb);
        pixel_t v_out;
        if (grb) begin
            v_out = {rgb[G_OFS +: COL_W], rgb[R_OFS +: COL_W], rgb[B_OFS +: COL_W]};
        end else begin
            v_out = rgb;
        end
        return v_out;
    endfunction

endpackage

// File: rtl/ws2812_frame_streamer_timer.sv
// ----------------------------------------------------------------------------
// frame_tick_timer
// Free-running period timer. While i_en is high it counts 0..PERIOD-1 and
// raises o_tick for one cycle each time the count wraps; the first tick is
// seen PERIOD cycles after i_en rises. With i_en low the count is parked at
// zero and no tick is produced. Generic enough for any periodic strobe.
//
// Ports:
//   clk     in   system clock
//   rst_n   in   asynchronous active-low reset
//   i_en    in   enable counting
//   o_tick  out  registered one-cycle strobe, once per PERIOD cycles
// ----------------------------------------------------------------------------
module frame_tick_timer
    import ws2812_pkg::*;
#(
    parameter int PERIOD = CLK_HZ / 60
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_en,
    output logic o_tick
);

    localparam int CNT_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(PERIOD - 1);

    logic [CNT_W-1:0] r_count;
    logic             r_tick;

    // Period counter and registered wrap strobe; disabled means parked at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
            r_tick  <= 1'b0;
        end else if (i_en) begin
            if (r_count == LAST_CNT) begin
                r_count <= '0;
            end else begin
                r_count <= r_count + 1'b1;
            end
            r_tick <= (r_count == LAST_CNT);
        end else begin
            r_count <= '0;
            r_tick  <= 1'b0;
        end
    end

    assign o_tick = r_tick;

endmodule

// File: rtl/ws2812_frame_streamer.sv
// ----------------------------------------------------------------------------
// ws2812_frame_streamer
// Upstream feeder for the WS2812 bit serializer. The host fills a shadow
// frame buffer at any time; a frame request (start pulse, periodic tick, or
// a request remembered while busy) snapshots shadow into the active buffer
// and the active pixels are streamed one per valid/ready transfer, already
// reordered into wire colour order. Bit timing and the latch gap belong to
// the serializer.
//
// Ports:
//   clk           in   system clock (50 MHz)
//   rst_n         in   asynchronous active-low reset; aborts a frame at once
//   i_wr_en       in   shadow write strobe
//   i_wr_addr     in   pixel index; indices >= NUM_LEDS are ignored
//   i_wr_data     in   pixel colour {R,G,B}
//   i_start       in   single-cycle frame request
//   i_auto_en     in   enable periodic frames every FRAME_PERIOD cycles
//   o_pix_data    out  wire-ordered pixel, held while stalled
//   o_pix_valid   out  o_pix_data valid
//   i_pix_ready   in   serializer accepts the pixel
//   o_pix_last    out  final pixel of the frame
//   o_busy        out  frame in progress (load or stream)
//   o_frame_done  out  one-cycle pulse after the last pixel is accepted
// ----------------------------------------------------------------------------
module ws2812_frame_streamer
    import ws2812_pkg::*;
#(
    parameter int NUM_LEDS     = 8,
    parameter int FRAME_PERIOD = CLK_HZ / 60,
    parameter int GRB_ORDER    = 1,
    parameter int ADDR_W       = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [PIX_W-1:0]  i_wr_data,
    input  logic              i_start,
    input  logic              i_auto_en,
    output logic [PIX_W-1:0]  o_pix_data,
    output logic              o_pix_valid,
    input  logic              i_pix_ready,
    output logic              o_pix_last,
    output logic              o_busy,
    output logic              o_frame_done
);

    localparam int               IDX_W    = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_LEDS - 1);
    localparam logic             GRB_SEL  = (GRB_ORDER != 0);
    localparam logic             ONE_PIX  = (NUM_LEDS == 1);

    pixel_t           r_shadow [NUM_LEDS];
    pixel_t           r_active [NUM_LEDS];
    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [IDX_W-1:0] r_idx;
    logic [IDX_W-1:0] w_idx_inc;
    logic             r_pending;
    pixel_t           r_pix_data;
    logic             r_pix_valid;
    logic             r_pix_last;
    logic             r_busy;
    logic             r_frame_done;

    logic             w_tick;
    logic             w_new_req;
    logic             w_req;
    logic             w_xfer;
    logic             w_wr_hit;
    logic [IDX_W-1:0] w_wr_idx;

    frame_tick_timer #(
        .PERIOD (FRAME_PERIOD)
    ) u_frame_tick_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_en   (i_auto_en),
        .o_tick (w_tick)
    );

    // A start and a tick in the same cycle are one request.
    assign w_new_req = i_start | w_tick;
    assign w_req     = w_new_req | r_pending;
    assign w_xfer    = r_pix_valid & i_pix_ready;
    assign w_idx_inc = r_idx + 1'b1;
    assign w_wr_hit  = i_wr_en && ({1'b0, i_wr_addr} < (ADDR_W + 1)'(NUM_LEDS));
    assign w_wr_idx  = i_wr_addr[IDX_W-1:0];

    // Shadow buffer: host writes land here in any state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_LEDS; i++) begin
                r_shadow[i] <= '0;
            end
        end else if (w_wr_hit) begin
            r_shadow[w_wr_idx] <= i_wr_data;
        end
    end

    // Active buffer: snapshot of shadow taken during LOAD. The copy sees the
    // shadow contents before this cycle's write, so a write during LOAD only
    // reaches the next frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_LEDS; i++) begin
                r_active[i] <= '0;
            end
        end else if (r_state == ST_LOAD) begin
            for (int i = 0; i < NUM_LEDS; i++) begin
                r_active[i] <= r_shadow[i];
            end
        end
    end

    // Next-state logic of the frame sequencer.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_req) begin
                    w_state_nxt = ST_LOAD;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_LOAD: begin
                w_state_nxt = ST_STREAM;
            end
            ST_STREAM: begin
                if (w_xfer && r_pix_last) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_state_nxt = ST_STREAM;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State register and status outputs registered from the next state so
    // they line up with the state they describe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
            r_pix_valid  <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_busy       <= (w_state_nxt == ST_LOAD) || (w_state_nxt == ST_STREAM);
            r_frame_done <= (w_state_nxt == ST_DONE);
            r_pix_valid  <= (w_state_nxt == ST_STREAM);
        end
    end

    // One-deep request memory: any request outside IDLE is remembered, and
    // leaving IDLE (always into LOAD when a request exists) consumes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending <= 1'b0;
        end else if (r_state == ST_IDLE) begin
            r_pending <= 1'b0;
        end else if (w_new_req) begin
            r_pending <= 1'b1;
        end
    end

    // Pixel index and output pixel/last registers. The first pixel is taken
    // straight from shadow during LOAD (identical to what active will hold);
    // afterwards data only advances on a transfer, so it is stable under stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx      <= '0;
            r_pix_data <= '0;
            r_pix_last <= 1'b0;
        end else begin
            case (r_state)
                ST_LOAD: begin
                    r_idx      <= '0;
                    r_pix_data <= grb_reorder(r_shadow[0], GRB_SEL);
                    r_pix_last <= ONE_PIX;
                end
                ST_STREAM: begin
                    if (w_xfer) begin
                        if (r_pix_last) begin
                            r_pix_last <= 1'b0;
                        end else begin
                            r_idx      <= w_idx_inc;
                            r_pix_data <= grb_reorder(r_active[w_idx_inc], GRB_SEL);
                            r_pix_last <= (w_idx_inc == LAST_IDX);
                        end
                    end
                end
                default: begin
                    r_pix_last <= 1'b0;
                end
            endcase
        end
    end

    assign o_pix_data   = r_pix_data;
    assign o_pix_valid  = r_pix_valid;
    assign o_pix_last   = r_pix_last;
    assign o_busy       = r_busy;
    assign o_frame_done = r_frame_done;

endmodule

// File: tb/tb_ws2812_frame_streamer.sv
// ----------------------------------------------------------------------------
// tb_ws2812_frame_streamer
// Scoreboard bench: each frame request pushes the expected wire-ordered
// pixels (computed from a plain array mirror of the host writes) into a
// queue; an independent monitor compares every presented pixel against the
// queue head and pops on each accepted transfer.
// ----------------------------------------------------------------------------
module tb_ws2812_frame_streamer;

    localparam int NL = 4;
    localparam int FP = 10;
    localparam int AW = 8;

    logic          clk       = 1'b0;
    logic          rst_n     = 1'b0;
    logic          wr_en     = 1'b0;
    logic [AW-1:0] wr_addr   = '0;
    logic [23:0]   wr_data   = '0;
    logic          start     = 1'b0;
    logic          auto_en   = 1'b0;
    logic          pix_ready = 1'b0;
    logic [23:0]   pix_data;
    logic          pix_valid;
    logic          pix_last;
    logic          busy;
    logic          frame_done;

    ws2812_frame_streamer #(
        .NUM_LEDS     (NL),
        .FRAME_PERIOD (FP),
        .GRB_ORDER    (1),
        .ADDR_W       (AW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_wr_en      (wr_en),
        .i_wr_addr    (wr_addr),
        .i_wr_data    (wr_data),
        .i_start      (start),
        .i_auto_en    (auto_en),
        .o_pix_data   (pix_data),
        .o_pix_valid  (pix_valid),
        .i_pix_ready  (pix_ready),
        .o_pix_last   (pix_last),
        .o_busy       (busy),
        .o_frame_done (frame_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [23:0] d;
        logic        l;
    } exp_t;

    exp_t        sb[$];
    logic [23:0] model[NL];
    int          rises[$];
    int          n_vec     = 0;
    int          n_err     = 0;
    bit          in_reset  = 1'b1;
    bit          exp_done  = 1'b0;
    int          rdy_mode  = 0;
    logic        prev_busy = 1'b0;

    function automatic logic [23:0] wire_order(input logic [23:0] rgb);
        return {rgb[15:8], rgb[23:16], rgb[7:0]};
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic push_frame();
        exp_t e;
        for (int i = 0; i < NL; i++) begin
            e.d = wire_order(model[i]);
            e.l = (i == NL - 1);
            sb.push_back(e);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        start = 1'b0;
    endtask

    task automatic wr(input int a, input logic [23:0] d);
        wr_en   = 1'b1;
        wr_addr = AW'(a);
        wr_data = d;
        if (a < NL) model[a] = d;
        step();
    endtask

    task automatic go();
        start = 1'b1;
        push_frame();
        step();
    endtask

    task automatic wait_done(input string nm);
        int k;
        bit seen;
        k = 0;
        seen = 1'b0;
        while (!seen && k < 400) begin
            @(negedge clk);
            if (frame_done === 1'b1) seen = 1'b1;
            k++;
        end
        check({nm, "_done_seen"}, 32'(seen), 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic watch(input int from, input int to);
        for (int c = from; c <= to; c++) begin
            @(negedge clk);
            if (busy === 1'b1 && prev_busy === 1'b0) rises.push_back(c);
            prev_busy = busy;
        end
    endtask

    // Ready driver: always-ready, 0,0,1 stall pattern, random, or held low.
    initial begin
        int rc;
        rc = 0;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0: pix_ready = 1'b1;
                1: begin
                    rc = (rc + 1) % 3;
                    pix_ready = (rc == 2);
                end
                2: pix_ready = 1'($urandom_range(0, 1));
                default: pix_ready = 1'b0;
            endcase
        end
    end

    // Monitor: compare presented pixels with the scoreboard head, pop on transfer.
    initial begin
        forever begin
            @(negedge clk);
            if (in_reset) begin
                exp_done = 1'b0;
            end else begin
                if (exp_done) begin
                    check("frame_done", 32'(frame_done), 32'd1);
                    check("busy_at_done", 32'(busy), 32'd0);
                    check("valid_at_done", 32'(pix_valid), 32'd0);
                    exp_done = 1'b0;
                end else begin
                    check("frame_done_spurious", 32'(frame_done), 32'd0);
                end
                if (pix_valid === 1'b1) begin
                    if (sb.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL unexpected_pixel: got %h with no pixel expected (t=%0t)", pix_data, $time);
                    end else begin
                        check("pix_data", 32'(pix_data), 32'(sb[0].d));
                        check("pix_last", 32'(pix_last), 32'(sb[0].l));
                        if (pix_ready === 1'b1) begin
                            exp_done = sb[0].l;
                            void'(sb.pop_front());
                        end
                    end
                end
            end
        end
    end

    // Watchdog: the run must never hang.
    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < NL; i++) model[i] = 24'h0;
        #3;
        check("rst_pix_data", 32'(pix_data), 32'd0);
        check("rst_pix_valid", 32'(pix_valid), 32'd0);
        check("rst_pix_last", 32'(pix_last), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        in_reset = 1'b0;
        repeat (2) step();

        // Basic frame, latency and out-of-range write.
        rdy_mode = 0;
        wr(0, 24'hFF0000);
        wr(1, 24'h00FF00);
        wr(6, 24'hABCDEF);
        wr(4, 24'h777777);
        go();
        @(negedge clk);
        check("load_busy", 32'(busy), 32'd1);
        check("load_valid", 32'(pix_valid), 32'd0);
        @(negedge clk);
        check("first_valid_latency", 32'(pix_valid), 32'd1);
        wait_done("basic");

        // Backpressure with a 0,0,1 ready pattern.
        rdy_mode = 1;
        wr(2, 24'h0A0B0C);
        wr(3, 24'h112233);
        go();
        wait_done("backpressure");
        rdy_mode = 0;

        // Coherency: writes during LOAD and mid-stream reach only the next frame.
        go();
        wr(0, 24'h123456);
        step();
        step();
        wr(0, 24'h123456);
        wait_done("coherency1");
        go();
        wait_done("coherency2");

        // Pending: three starts while busy give exactly one extra frame.
        rdy_mode = 1;
        go();
        step();
        start = 1'b1;
        push_frame();
        step();
        step();
        start = 1'b1;
        step();
        start = 1'b1;
        step();
        wait_done("pending1");
        @(negedge clk);
        check("pending_idle_gap", 32'(busy), 32'd0);
        @(negedge clk);
        check("pending_load", 32'(busy), 32'd1);
        @(posedge clk);
        #1;
        wait_done("pending2");
        repeat (20) step();
        @(negedge clk);
        check("no_third_frame", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        rdy_mode = 0;

        // Auto frames every FP cycles, then stop; re-enable restarts from zero.
        prev_busy = 1'b0;
        rises.delete();
        push_frame();
        push_frame();
        push_frame();
        auto_en = 1'b1;
        step();
        watch(1, 35);
        @(posedge clk);
        #1;
        auto_en = 1'b0;
        watch(36, 75);
        check("auto_rise_count", 32'(rises.size()), 32'd3);
        for (int i = 0; i < 3; i++) begin
            int r;
            r = (i < rises.size()) ? rises[i] : -1;
            check("auto_rise_cycle", 32'(r), 32'(FP + 1 + i * FP));
        end
        rises.delete();
        @(posedge clk);
        #1;
        push_frame();
        auto_en = 1'b1;
        step();
        watch(1, 15);
        @(posedge clk);
        #1;
        auto_en = 1'b0;
        watch(16, 40);
        check("auto_reenable_count", 32'(rises.size()), 32'd1);
        check("auto_reenable_cycle", 32'((rises.size() > 0) ? rises[0] : -1), 32'(FP + 1));
        @(posedge clk);
        #1;

        // Randomized writes, ready and frames.
        rdy_mode = 2;
        for (int f = 0; f < 12; f++) begin
            int nw;
            nw = int'($urandom_range(1, 6));
            for (int w = 0; w < nw; w++) wr(int'($urandom_range(0, 7)), 24'($urandom));
            go();
            for (int w = 0; w < 3; w++) wr(int'($urandom_range(0, 7)), 24'($urandom));
            wait_done("random");
        end

        // Reset mid-stream at pixel 3.
        rdy_mode = 0;
        model[3] = 24'hC0FFEE;
        wr(3, 24'hC0FFEE);
        go();
        repeat (4) @(posedge clk);
        #2;
        check("pre_reset_valid", 32'(pix_valid), 32'd1);
        check("pre_reset_pix3", 32'(pix_data), 32'(wire_order(model[3])));
        in_reset = 1'b1;
        rst_n    = 1'b0;
        sb.delete();
        for (int i = 0; i < NL; i++) model[i] = 24'h0;
        #1;
        check("async_rst_pix_data", 32'(pix_data), 32'd0);
        check("async_rst_pix_valid", 32'(pix_valid), 32'd0);
        check("async_rst_pix_last", 32'(pix_last), 32'd0);
        check("async_rst_busy", 32'(busy), 32'd0);
        check("async_rst_frame_done", 32'(frame_done), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n    = 1'b1;
        in_reset = 1'b0;
        repeat (10) step();
        @(negedge clk);
        check("idle_after_reset_busy", 32'(busy), 32'd0);
        check("idle_after_reset_valid", 32'(pix_valid), 32'd0);
        @(posedge clk);
        #1;
        go();
        wait_done("zero_frame");

        repeat (3) step();
        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ws2812_frame_streamer.md
Name: ws2812_frame_streamer

Overview:
- Upstream feeder for the single-pixel WS2812 bit serializer.
- Holds a double-buffered frame of NUM_LEDS 24-bit RGB pixels written by the host/control logic.
- On a frame request (explicit start or internal frame-rate tick), snapshots the frame and streams it one pixel at a time, in wire colour order, over a valid/ready handshake.
- The downstream serializer owns bit timing and the 50 us latch gap; this block only sequences pixels.

Parameters:
- NUM_LEDS, 8, pixels per frame (1..256).
- FRAME_PERIOD, 833_333, clk cycles between auto frames (60 Hz at 50 MHz); minimum 2.
- GRB_ORDER, 1, 1: output {G,R,B}; 0: output {R,G,B} unchanged.
- ADDR_W, 8, width of wr_addr.

Ports:
- clk  in  1  system clock, 50 MHz.
- rst_n  in  1  reset, asynchronous, active-low.
- wr_en  in  1  write strobe into shadow buffer.
- wr_addr  in  ADDR_W  pixel index.
- wr_data  in  24  pixel colour {R[23:16],G[15:8],B[7:0]}.
- start  in  1  single-cycle frame request.
- auto_en  in  1  enables periodic frames every FRAME_PERIOD cycles.
- pix_data  out  24  pixel to serializer, MSB sent first.
- pix_valid  out  1  pix_data valid.
- pix_ready  in  1  serializer accepts pixel.
- pix_last  out  1  high with the final pixel of a frame.
- busy  out  1  frame in progress (LOAD or STREAM).
- frame_done  out  1  one-cycle pulse after the last pixel is accepted.

Behaviour:
- Reset (async, rst_n low): pix_data=0, pix_valid=0, pix_last=0, busy=0, frame_done=0. Shadow and active buffers are cleared to 0. Pending flag, index and timer cleared. State=IDLE. Reset mid-frame aborts immediately; the serializer sees pix_valid drop asynchronously.
- Shadow writes: on wr_en with wr_addr<NUM_LEDS, shadow[wr_addr]<=wr_data, in any state. wr_addr>=NUM_LEDS is ignored.
- Frame request: req = start | tick | pending. A start or tick arriving while busy sets pending (one deep; extra requests coalesce). pending clears on entering LOAD.
- Auto timer: while auto_en=1, counts 0..FRAME_PERIOD-1 and pulses tick for one cycle at FRAME_PERIOD-1, then wraps to 0. auto_en=0 holds the counter at 0 with no tick. The first tick occurs FRAME_PERIOD cycles after auto_en rises.
- FSM states and transitions:
  - IDLE: if req, go to LOAD.
  - LOAD (1 cycle): active<=shadow, copied from shadow contents before this cycle's write. A write in this same cycle lands in shadow only and appears in the next frame. idx<=0; busy=1.
  - STREAM: pix_valid=1, pix_data=reorder(active[idx]), pix_last=(idx==NUM_LEDS-1). On pix_valid&pix_ready: if last, go to DONE; else idx<=idx+1.
  - DONE (1 cycle): frame_done=1, busy=0, pix_valid=0; then go to IDLE. A pending request goes to LOAD on the next cycle via IDLE.
- Latency: start at cycle N gives LOAD at N+1 and pix_valid=1 at N+2. With pix_ready held high, one pixel transfers per cycle.
- Handshake: pix_data and pix_last are registered and held stable while pix_valid&!pix_ready. pix_valid never drops without a transfer, except on reset.
- Reorder: GRB_ORDER=1 gives pix_data={G,R,B}.
- NUM_LEDS=1: the single pixel is both first and last.
- start and tick in the same cycle: one frame.

Decomposition:
- Shared package ws2812_pkg holds:
  - state encoding (IDLE, LOAD, STREAM, DONE);
  - CLK_HZ=50_000_000;
  - pixel width 24;
  - colour field offsets;
  - a grb_reorder function.
- One sub-module: frame_tick_timer (counter, auto_en, tick output), reusable by the serializer-side colour timer.

Test Plan:
- Write pixel 0=0xFF0000 and pixel 1=0x00FF00 (NUM_LEDS=2, GRB_ORDER=1), pulse start with pix_ready=1 → pix_valid at start+2. Output 0x00FF00 then 0xFF0000. pix_last on the 2nd pixel. frame_done one cycle after; busy low.
- Backpressure: pix_ready toggles 0,0,1 per pixel → pix_data/pix_last stable during stalls. Every pixel is emitted exactly once, in order.
- Coherency: write pixel 0=0x123456 in the LOAD cycle, then again mid-STREAM → current frame shows the old value; the next frame shows 0x123456.
- Pending: pulse start three times during busy → exactly one extra frame follows DONE, starting LOAD two cycles after frame_done.
- Auto: FRAME_PERIOD=10, auto_en=1, pix_ready=1 → LOAD every 10 cycles. Drop auto_en → no further frames; counter returns to 0.
- Reset mid-STREAM at pixel 3 → all outputs 0 immediately. After release with no request, stays IDLE. Buffers read back as 0 on the next frame.
